// File: rtl/retire_stage.sv
// Retire stage: commits up to three renamed instructions per cycle in age order,
// maintains the architectural rename map and sequences squash/recover on redirects.
module retire_stage #(
    parameter int XLEN = 32,
    parameter int PRW  = 6,
    parameter int ARN  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [2:0]                ret_valid,
    input  logic [2:0][4:0]           ret_arch_dest,
    input  logic [2:0][PRW-1:0]       ret_phys_dest,
    input  logic [2:0][PRW-1:0]       ret_prev_phys,
    input  logic [2:0]                ret_precise,
    input  logic [2:0][XLEN-1:0]      ret_target_pc,
    input  logic [2:0]                ret_halt,
    output logic [2:0]                free_valid,
    output logic [2:0][PRW-1:0]       free_preg,
    output logic                      squash,
    output logic                      redirect_valid,
    output logic [XLEN-1:0]           redirect_pc,
    output logic                      recover_valid,
    output logic [ARN-1:0][PRW-1:0]   arch_map,
    output logic [63:0]               retired_count,
    output logic                      halted
);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        SQUASH  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]      commit;
    logic [2:0]      free_mask;
    logic            precise_hit;
    logic            halt_hit;
    logic [XLEN-1:0] hit_pc;
    logic            stop;
    logic [1:0]      commit_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // Lanes are walked oldest first; the first halt or precise lane commits and
    // blocks everything younger. Halt is checked first so halt+precise acts as halt.
    always_comb begin
        state_next  = state;
        commit      = '0;
        stop        = 1'b0;
        precise_hit = 1'b0;
        halt_hit    = 1'b0;
        hit_pc      = '0;
        case (state)
            NORMAL: begin
                if (!halted) begin
                    for (int l = 2; l >= 0; l--) begin
                        if (ret_valid[l] && !stop) begin
                            commit[l] = 1'b1;
                            if (ret_halt[l]) begin
                                halt_hit = 1'b1;
                                stop     = 1'b1;
                            end else if (ret_precise[l]) begin
                                precise_hit = 1'b1;
                                hit_pc      = ret_target_pc[l];
                                stop        = 1'b1;
                            end
                        end
                    end
                end
                if (precise_hit) begin
                    state_next = SQUASH;
                end
            end
            SQUASH:  state_next = RECOVER;
            RECOVER: state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    always_comb begin
        free_mask = '0;
        for (int l = 0; l < 3; l++) begin
            free_mask[l] = commit[l] && (ret_arch_dest[l] != 5'd0);
        end
        commit_count = 2'(commit[2]) + 2'(commit[1]) + 2'(commit[0]);
    end

    // Map writes are issued oldest lane first so the youngest writer of a
    // shared destination lands last and wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARN; i++) begin
                arch_map[i] <= PRW'(i);
            end
            retired_count <= '0;
            halted        <= 1'b0;
        end else begin
            for (int l = 2; l >= 0; l--) begin
                if (free_mask[l]) begin
                    arch_map[ret_arch_dest[l]] <= ret_phys_dest[l];
                end
            end
            retired_count <= retired_count + 64'(commit_count);
            if (halt_hit) begin
                halted <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_valid     <= '0;
            free_preg      <= '0;
            squash         <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            recover_valid  <= 1'b0;
        end else begin
            free_valid <= free_mask;
            for (int l = 0; l < 3; l++) begin
                if (free_mask[l]) begin
                    free_preg[l] <= ret_prev_phys[l];
                end
            end
            squash         <= precise_hit;
            redirect_valid <= precise_hit;
            if (precise_hit) begin
                redirect_pc <= hit_pc;
            end
            recover_valid <= (state == SQUASH);
        end
    end

endmodule

// File: tb/tb_retire_stage.sv
// Testbench for retire_stage: table of retire bundles with expected commit masks,
// a reference map/count model and a scoreboard queue of expected outputs.
module tb_retire_stage;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        ret_valid = '0;
    logic [2:0][4:0]   ret_arch_dest = '0;
    logic [2:0][5:0]   ret_phys_dest = '0;
    logic [2:0][5:0]   ret_prev_phys = '0;
    logic [2:0]        ret_precise = '0;
    logic [2:0][31:0]  ret_target_pc = '0;
    logic [2:0]        ret_halt = '0;
    logic [2:0]        free_valid;
    logic [2:0][5:0]   free_preg;
    logic              squash;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              recover_valid;
    logic [31:0][5:0]  arch_map;
    logic [63:0]       retired_count;
    logic              halted;

    int checks = 0;
    int failures = 0;

    retire_stage dut (
        .clock(clock), .reset(reset),
        .ret_valid(ret_valid), .ret_arch_dest(ret_arch_dest),
        .ret_phys_dest(ret_phys_dest), .ret_prev_phys(ret_prev_phys),
        .ret_precise(ret_precise), .ret_target_pc(ret_target_pc), .ret_halt(ret_halt),
        .free_valid(free_valid), .free_preg(free_preg), .squash(squash),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .recover_valid(recover_valid), .arch_map(arch_map),
        .retired_count(retired_count), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]       valid;
        logic [2:0]       precise;
        logic [2:0]       halt;
        logic [2:0][4:0]  adest;
        logic [2:0][5:0]  pdest;
        logic [2:0][5:0]  prev;
        logic [2:0][31:0] tpc;
        logic [2:0]       commits;
        logic [2:0]       exp_free;
        logic             exp_squash;
        logic             exp_redirect;
        logic             exp_recover;
        logic             exp_halted;
        logic [31:0]      exp_pc;
    } vec_t;

    typedef struct {
        logic [2:0]       free_valid;
        logic [2:0][5:0]  free_preg;
        logic             squash;
        logic             redirect;
        logic             recover;
        logic             halted;
        logic [31:0]      pc;
        logic [63:0]      count;
        logic [31:0][5:0] map;
    } exp_t;

    exp_t             sb[$];
    logic [31:0][5:0] model_map;
    logic [63:0]      model_count;
    vec_t             vecs[11];

    function automatic vec_t mkVec(
        input logic [2:0] valid, input logic [2:0] precise, input logic [2:0] halt,
        input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
        input logic [5:0] p2, input logic [5:0] p1, input logic [5:0] p0,
        input logic [5:0] q2, input logic [5:0] q1, input logic [5:0] q0,
        input logic [31:0] tbase, input logic [2:0] commits, input logic [2:0] efree,
        input logic esq, input logic erd, input logic erc, input logic eh,
        input logic [31:0] epc);
        vec_t v;
        v.valid = valid; v.precise = precise; v.halt = halt;
        v.adest[2] = a2; v.adest[1] = a1; v.adest[0] = a0;
        v.pdest[2] = p2; v.pdest[1] = p1; v.pdest[0] = p0;
        v.prev[2] = q2;  v.prev[1] = q1;  v.prev[0] = q0;
        v.tpc[1] = tbase;
        v.tpc[2] = tbase + 32'h1000;
        v.tpc[0] = tbase + 32'h2000;
        v.commits = commits; v.exp_free = efree;
        v.exp_squash = esq; v.exp_redirect = erd; v.exp_recover = erc;
        v.exp_halted = eh; v.exp_pc = epc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkState(input exp_t e);
        checkOutput("free_valid", 64'(free_valid), 64'(e.free_valid));
        for (int l = 0; l < 3; l++) begin
            if (e.free_valid[l]) begin
                checkOutput($sformatf("free_preg[%0d]", l), 64'(free_preg[l]), 64'(e.free_preg[l]));
            end
        end
        checkOutput("squash", 64'(squash), 64'(e.squash));
        checkOutput("redirect_valid", 64'(redirect_valid), 64'(e.redirect));
        if (e.redirect) begin
            checkOutput("redirect_pc", 64'(redirect_pc), 64'(e.pc));
        end
        checkOutput("recover_valid", 64'(recover_valid), 64'(e.recover));
        checkOutput("halted", 64'(halted), 64'(e.halted));
        checkOutput("retired_count", retired_count, e.count);
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("arch_map[%0d]", i), 64'(arch_map[i]), 64'(e.map[i]));
        end
    endtask

    // Drives one bundle, predicts the result from the model, checks one cycle later.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        ret_valid = v.valid; ret_precise = v.precise; ret_halt = v.halt;
        ret_arch_dest = v.adest; ret_phys_dest = v.pdest;
        ret_prev_phys = v.prev; ret_target_pc = v.tpc;
        for (int l = 2; l >= 0; l--) begin
            if (v.commits[l]) begin
                model_count = model_count + 64'd1;
                if (v.adest[l] != 5'd0) model_map[v.adest[l]] = v.pdest[l];
            end
        end
        e.free_valid = v.exp_free;
        e.free_preg = v.prev;
        e.squash = v.exp_squash; e.redirect = v.exp_redirect;
        e.recover = v.exp_recover; e.halted = v.exp_halted;
        e.pc = v.exp_pc; e.count = model_count; e.map = model_map;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL scoreboard: got empty queue expected one entry");
        end else begin
            checkState(sb.pop_front());
        end
    endtask

    task automatic doReset(input logic junk);
        exp_t e;
        reset = 1'b1;
        ret_valid = junk ? 3'b111 : 3'b000;
        ret_precise = junk ? 3'b100 : 3'b000;
        ret_halt = '0;
        ret_arch_dest = junk ? {5'd4, 5'd5, 5'd6} : '0;
        ret_phys_dest = junk ? {6'd44, 6'd45, 6'd46} : '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model_map[i] = 6'(i);
        model_count = '0;
        e.free_valid = '0; e.free_preg = '0; e.squash = 0; e.redirect = 0;
        e.recover = 0; e.halted = 0; e.pc = '0; e.count = '0; e.map = model_map;
        checkState(e);
        checkOutput("reset redirect_pc", 64'(redirect_pc), 64'd0);
        checkOutput("reset free_preg", 64'(free_preg), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //                valid   prec    halt    a2 a1 a0  p2 p1 p0  q2 q1 q0  tbase      commit  free  sq rd rc h  pc
        vecs[0]  = mkVec(3'b111, 3'b000, 3'b000, 1, 2, 3,   33,34,35, 1, 2, 3,  32'h0,     3'b111, 3'b111, 0,0,0,0, 32'h0);
        vecs[1]  = mkVec(3'b111, 3'b000, 3'b000, 5, 6, 5,   40,42,41, 5, 6, 45, 32'h0,     3'b111, 3'b111, 0,0,0,0, 32'h0);
        vecs[2]  = mkVec(3'b100, 3'b000, 3'b000, 0, 0, 0,   50,0, 0,  7, 0, 0,  32'h0,     3'b100, 3'b000, 0,0,0,0, 32'h0);
        vecs[3]  = mkVec(3'b111, 3'b010, 3'b000, 7, 8, 9,   51,52,53, 7, 8, 9,  32'h100,   3'b110, 3'b110, 1,1,0,0, 32'h100);
        vecs[4]  = mkVec(3'b111, 3'b100, 3'b000, 10,11,12,  60,61,62, 10,11,12, 32'h500,   3'b000, 3'b000, 0,0,1,0, 32'h0);
        vecs[5]  = mkVec(3'b111, 3'b001, 3'b000, 13,14,15,  63,1, 2,  13,14,15, 32'h600,   3'b000, 3'b000, 0,0,0,0, 32'h0);
        vecs[6]  = mkVec(3'b110, 3'b000, 3'b000, 10,11,0,   54,55,0,  10,11,0, 32'h0,     3'b110, 3'b110, 0,0,0,0, 32'h0);
        vecs[7]  = mkVec(3'b000, 3'b000, 3'b000, 20,21,22,  9, 9, 9,  1, 1, 1,  32'h0,     3'b000, 3'b000, 0,0,0,0, 32'h0);
        vecs[8]  = mkVec(3'b111, 3'b010, 3'b010, 12,13,14,  56,57,58, 12,13,14, 32'h200,   3'b110, 3'b110, 0,0,0,1, 32'h0);
        vecs[9]  = mkVec(3'b111, 3'b000, 3'b000, 16,17,18,  20,21,22, 16,17,18, 32'h0,     3'b000, 3'b000, 0,0,0,1, 32'h0);
        vecs[10] = mkVec(3'b111, 3'b100, 3'b000, 19,20,21,  23,24,25, 19,20,21, 32'h700,   3'b000, 3'b000, 0,0,0,1, 32'h0);

        $display("[TB] reset state");
        doReset(1'b0);

        $display("[TB] table vectors");
        for (int k = 0; k < 11; k++) begin
            applyStimulus(vecs[k]);
        end

        $display("[TB] reset while squash is high");
        doReset(1'b0);
        applyStimulus(mkVec(3'b100, 3'b100, 3'b000, 1, 0, 0, 60, 0, 0, 1, 0, 0,
                            32'h2300, 3'b100, 3'b100, 1, 1, 0, 0, 32'h3300));
        doReset(1'b1);
        applyStimulus(mkVec(3'b100, 3'b000, 3'b000, 1, 0, 0, 60, 0, 0, 1, 0, 0,
                            32'h0, 3'b100, 3'b100, 0, 0, 0, 0, 32'h0));

        $display("[TB] halt on oldest lane");
        applyStimulus(mkVec(3'b111, 3'b000, 3'b100, 2, 3, 4, 61, 62, 63, 2, 3, 4,
                            32'h0, 3'b100, 3'b100, 0, 0, 0, 1, 32'h0));
        applyStimulus(mkVec(3'b111, 3'b000, 3'b000, 5, 6, 7, 11, 12, 13, 5, 6, 7,
                            32'h0, 3'b000, 3'b000, 0, 0, 0, 1, 32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/retire_stage.md
RETIRE_STAGE -- requirements
Module: retire_stage

Parameters
REQ-001 XLEN, 32, width of program counter values.
REQ-002 PRW, 6, physical register index width (64 physical registers).
REQ-003 ARN, 32, number of architectural registers; index width is 5.

Interface
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ret_valid  input  3  per-lane retire valid; lane 2 oldest, lane 0 youngest; valid lanes contiguous from lane 2 downward.
REQ-007 ret_arch_dest  input  3x5  per-lane architectural destination.
REQ-008 ret_phys_dest  input  3xPRW  per-lane new physical destination.
REQ-009 ret_prev_phys  input  3xPRW  per-lane previously mapped physical register.
REQ-010 ret_precise  input  3  per-lane precise-state-needed flag (mispredict/exception).
REQ-011 ret_target_pc  input  3xXLEN  per-lane redirect PC, meaningful only when ret_precise is set.
REQ-012 ret_halt  input  3  per-lane halt instruction flag.
REQ-013 free_valid  output  3  registered; per-lane freed physical register valid.
REQ-014 free_preg  output  3xPRW  registered; freed physical register per lane.
REQ-015 squash  output  1  registered; pipeline flush pulse.
REQ-016 redirect_valid  output  1  registered; fetch redirect pulse.
REQ-017 redirect_pc  output  XLEN  registered; fetch redirect target.
REQ-018 recover_valid  output  1  registered; rename map restore pulse.
REQ-019 arch_map  output  ARNxPRW  current architectural map table contents.
REQ-020 retired_count  output  64  total committed instructions.
REQ-021 halted  output  1  sticky; a halt instruction has committed.

Function
REQ-022 State machine states: NORMAL, SQUASH, RECOVER.
REQ-023 In NORMAL, lanes commit in age order (2, 1, 0); a lane commits if it is valid and no older lane in the same cycle carried ret_precise or ret_halt.
REQ-024 The first committing lane with ret_precise or ret_halt set still commits itself; all younger lanes that cycle are discarded.
REQ-025 A committing lane with arch_dest != 0 writes arch_map[arch_dest] <= phys_dest and, next cycle, asserts free_valid for that lane with free_preg = prev_phys.
REQ-026 A committing lane with arch_dest == 0 writes no map entry and frees nothing, but counts as committed.
REQ-027 Same arch_dest committed by several lanes in one cycle: the youngest committing lane's phys_dest is the final map value; every lane's prev_phys is still freed.
REQ-028 retired_count increments by the number of committing lanes (0-3), wrapping modulo 2^64.
REQ-029 A committed ret_precise transitions NORMAL -> SQUASH; the next cycle asserts squash=1 and redirect_valid=1 with redirect_pc = that lane's ret_target_pc, for exactly one cycle.
REQ-030 SQUASH lasts one cycle, then goes to RECOVER: recover_valid=1 for one cycle with arch_map stable, then back to NORMAL.
REQ-031 In SQUASH and RECOVER, all ret_* inputs are ignored: no map writes, no frees, no count.
REQ-032 A committed ret_halt sets halted=1 (sticky until reset); thereafter all retire inputs are ignored; halt and precise on the same lane are treated as halt only.
REQ-033 free_valid, squash, redirect_valid and recover_valid are single-cycle pulses and deassert when their triggering condition is absent.

Reset
REQ-034 Reset: state = NORMAL; arch_map[i] = i for all i; retired_count = 0; halted = 0; all pulse outputs = 0; redirect_pc = 0; free_preg = 0.
REQ-035 Reset asserted in SQUASH or RECOVER aborts the sequence; no squash, redirect or recover pulse is emitted in the cycle after reset.

Verification
REQ-036 3 lanes valid with arch_dest 1/2/3, phys 33/34/35, prev 1/2/3 -> next cycle arch_map[1..3] = 33/34/35; free_valid = 111; free_preg = 1/2/3; retired_count = 3.
REQ-037 Lane 1 has ret_precise with target 0x100, and lanes 2/1/0 are valid -> lanes 2 and 1 commit and lane 0 is dropped; count += 2. Next cycle squash = redirect_valid = 1 with redirect_pc = 0x100, then recover_valid = 1 the cycle after. Inputs presented during these two cycles are ignored.
REQ-038 Lanes 2 and 0 both target arch_dest 5 with phys 40 and 41 -> arch_map[5] = 41; both prev_phys values freed.
REQ-039 arch_dest 0 on lane 2 with phys 50 -> arch_map[0] stays 0; free_valid[2] = 0; count += 1.
REQ-040 ret_halt on lane 2 -> halted = 1 and count += 1; subsequent 3-lane bundles change nothing.
REQ-041 Reset asserted the cycle squash is high -> next cycle all pulses = 0; state = NORMAL; arch_map is identity.
